// File: rtl/load_align_ctrl.sv
// load_align_ctrl
//   Load-path controller between the LSU issue stage and data memory. It accepts
//   one load at a time and issues one word-aligned read, or two when the access
//   crosses a word boundary. It then merges and shifts the returned bytes and
//   returns the sign/zero-extended result through the embedded signext unit.
//
// Build option
//   MISALIGNED_SPLIT_EN  defined  : cross-word accesses take the two-read path.
//                        undefined: misaligned halfword/word loads fault
//                                   without touching memory. The second-read
//                                   states and the high/low word registers are
//                                   not built.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            load request handshake
//   req_addr, req_funct3           byte address, funct3 (LB/LH/LW/LBU/LHU)
//   mem_req/mem_gnt, mem_addr      word-aligned read request, held until grant
//   mem_rvalid, mem_rdata          read data return (little-endian)
//   rsp_valid/rsp_ready            result handshake, held until taken
//   rsp_data, rsp_fault            extended result, fault flag (data = 0)
module load_align_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_fault
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] SX_0700  = 3'd0;
  localparam logic [2:0] SX_1500  = 3'd1;
  localparam logic [2:0] SX_3100  = 3'd2;
  localparam logic [2:0] SXU_0700 = 3'd3;
  localparam logic [2:0] SXU_1500 = 3'd4;

`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_RESP  = 3'd5
  } state_t;
`endif

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic [2:0] sx_sel(input logic [2:0] f3);
    case (f3)
      F3_LB:   return SX_0700;
      F3_LH:   return SX_1500;
      F3_LBU:  return SXU_0700;
      F3_LHU:  return SXU_1500;
      default: return SX_3100;
    endcase
  endfunction

`ifdef MISALIGNED_SPLIT_EN
  // The access spills into the next word when its last byte lies beyond byte 3.
  function automatic logic word_cross(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_LH) || (f3 == F3_LHU)) && (off == 2'd3)) ||
           ((f3 == F3_LW) && (off != 2'd0));
  endfunction
`else
  // Without splitting, halfwords must be halfword-aligned and words word-aligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_LH) || (f3 == F3_LHU)) && off[0]) ||
           ((f3 == F3_LW) && (off != 2'd0));
  endfunction
`endif

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              f3_q, f3_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_fault_q, rsp_fault_d;
`ifdef MISALIGNED_SPLIT_EN
  logic                    cross_q, cross_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
  logic [2*DATA_WIDTH-1:0] pair;
  logic [2*DATA_WIDTH-1:0] shifted;
`else
  logic [DATA_WIDTH-1:0]   shifted;
`endif
  logic                    acc_fault;
  logic [ADDR_WIDTH-1:0]   word_base;
  logic [DATA_WIDTH-1:0]   aligned;
  logic [DATA_WIDTH-1:0]   ext_data;
  logic [2:0]              sx_op;

  // Request classification at accept time
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    acc_fault = !f3_legal(req_funct3);
`else
    acc_fault = !f3_legal(req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = acc_fault ? S_RESP : S_REQ0;
      end
      S_REQ0: begin
        if (mem_gnt) state_d = S_WAIT0;
      end
      S_WAIT0: begin
`ifdef MISALIGNED_SPLIT_EN
        if (mem_rvalid) state_d = cross_q ? S_REQ1 : S_RESP;
`else
        if (mem_rvalid) state_d = S_RESP;
`endif
      end
`ifdef MISALIGNED_SPLIT_EN
      S_REQ1: begin
        if (mem_gnt) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rvalid) state_d = S_RESP;
      end
`endif
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  assign word_base = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_data  = rsp_data_q;
    rsp_fault = rsp_fault_q;
    mem_req   = 1'b0;
    mem_addr  = '0;
    case (state_q)
      S_REQ0: begin
        mem_req  = 1'b1;
        mem_addr = word_base;
      end
`ifdef MISALIGNED_SPLIT_EN
      S_REQ1: begin
        mem_req  = 1'b1;
        mem_addr = word_base + ADDR_WIDTH'(4);  // wraps past the top of memory
      end
`endif
      default: ;
    endcase
  end

  // Byte alignment: the word arriving this cycle is merged with the one already
  // captured, so the result can be registered on the same edge as RESP entry.
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    pair    = {(state_q == S_WAIT1) ? mem_rdata : hi_q,
               (state_q == S_WAIT0) ? mem_rdata : lo_q};
    shifted = pair >> {addr_q[1:0], 3'b000};
`else
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
`endif
    aligned = shifted[DATA_WIDTH-1:0];
    sx_op   = sx_sel(f3_q);
  end

  signext #(
    .W(DATA_WIDTH)
  ) u_signext (
    .sx_op (sx_op),
    .din   (aligned),
    .dout  (ext_data)
  );

  // Request/data capture and response formation
  always_comb begin
    addr_d      = addr_q;
    f3_d        = f3_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
`ifdef MISALIGNED_SPLIT_EN
    cross_d     = cross_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          f3_d   = req_funct3;
`ifdef MISALIGNED_SPLIT_EN
          cross_d = word_cross(req_funct3, req_addr[1:0]);
`endif
          if (acc_fault) begin
            rsp_data_d  = '0;
            rsp_fault_d = 1'b1;
          end
        end
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
          lo_d = mem_rdata;
          if (!cross_q) begin
            rsp_data_d  = ext_data;
            rsp_fault_d = 1'b0;
          end
`else
          rsp_data_d  = ext_data;
          rsp_fault_d = 1'b0;
`endif
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      S_WAIT1: begin
        if (mem_rvalid) begin
          hi_d        = mem_rdata;
          rsp_data_d  = ext_data;
          rsp_fault_d = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  // Response registers (visible outputs, reset to zero)
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Request and read-word registers; only meaningful under the FSM, no reset
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    f3_q    <= f3_d;
`ifdef MISALIGNED_SPLIT_EN
    cross_q <= cross_d;
    lo_q    <= lo_d;
    hi_q    <= hi_d;
`endif
  end

endmodule

// signext: sign/zero extension of the low byte or halfword, or pass-through.
//   sx_op  0 SX_0700, 1 SX_1500, 2 SX_3100, 3 SXU_0700, 4 SXU_1500
module signext #(
  parameter int W = 32
) (
  input  logic [2:0]   sx_op,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam logic [2:0] SX_0700  = 3'd0;
  localparam logic [2:0] SX_1500  = 3'd1;
  localparam logic [2:0] SXU_0700 = 3'd3;
  localparam logic [2:0] SXU_1500 = 3'd4;

  always_comb begin
    dout = din;
    case (sx_op)
      SX_0700:  dout = {{(W-8){din[7]}}, din[7:0]};
      SX_1500:  dout = {{(W-16){din[15]}}, din[15:0]};
      SXU_0700: dout = {{(W-8){1'b0}}, din[7:0]};
      SXU_1500: dout = {{(W-16){1'b0}}, din[15:0]};
      default:  dout = din;
    endcase
  end

endmodule
